seq_signed_mul_ctrl: RTL

- Multi-cycle two's-complement multiplier controller that time-shares one sign-extending adder row (add/subtract plus sign extension) across all partial products, instead of a full array.
- Sequences radix-2 shift-add steps, negating on the multiplier MSB step, and wraps the datapath in a valid/ready handshake.
- Sits between the operand-source block and the result consumer in the part1 multiplier datapath.

---
 rtl/mul_pkg.sv | 22 ++
 rtl/mul_step_row.sv | 33 +++
 rtl/seq_signed_mul_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM encoding, counter sizing,
// and the SEQ_MUL_EARLY_TERM_EN build switch (early termination on zero remaining multiplier bits).
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold WIDTH itself, since it reaches WIDTH on the final step.
    function automatic int step_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

`ifdef SEQ_MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM_EN = 1'b1;
`else
    localparam bit EARLY_TERM_EN = 1'b0;
`endif

endpackage

// File: rtl/mul_step_row.sv
// Single sign-extending add/subtract row shared by every partial product.
// The sum is WIDTH+1 bits wide so the signed sum is exact and cannot overflow.
module mul_step_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             en_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   sum_o
);

    logic [WIDTH:0] acc_ext;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] addend;
    logic [WIDTH:0] cin;

    assign acc_ext = {acc_hi_i[WIDTH-1], acc_hi_i};
    assign a_ext   = {a_i[WIDTH-1], a_i};

    // Subtraction as add of the inverted operand with a carry-in of one.
    always_comb begin
        addend = '0;
        cin    = '0;
        if (en_i) begin
            addend = sub_i ? ~a_ext : a_ext;
            cin    = {{WIDTH{1'b0}}, sub_i};
        end
    end

    assign sum_o = acc_ext + addend + cin;

endmodule

// File: rtl/seq_signed_mul_ctrl.sv
// Radix-2 shift-add two's-complement multiplier with valid/ready handshakes on both sides.
// Define SEQ_MUL_EARLY_TERM_EN to finish early once the remaining multiplier bits are all zero.
module seq_signed_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = step_cnt_w(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    step_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH:0]   sum;
    logic             last_step;
    logic             early_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] q_d;

    // The multiplier MSB has negative weight, so the last step subtracts.
    assign last_step = (step_q == CW'(WIDTH - 1));

    mul_step_row #(.WIDTH(WIDTH)) u_row (
        .acc_hi_i (acc_q),
        .a_i      (a_q),
        .en_i     (q_q[0]),
        .sub_i    (last_step),
        .sum_o    (sum)
    );

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [2*WIDTH-1:0] shifted;

    // Unprocessed multiplier bits sit at the bottom of Q, WIDTH-step of them.
    assign rem_mask = {WIDTH{1'b1}} >> step_q;
    assign shifted  = $signed({acc_q, q_q}) >>> (CW'(WIDTH) - step_q);

    always_comb begin
        acc_d   = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        early_d = 1'b0;
        if ((q_q & rem_mask) == '0) begin
            early_d      = 1'b1;
            {acc_d, q_d} = shifted;
        end
    end
`else
    always_comb begin
        acc_d   = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        early_d = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= multiplicand;
                        q_q        <= multiplier;
                        acc_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    q_q    <= q_d;
                    step_q <= step_q + CW'(1);
                    if (last_step || early_d) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = {acc_q, q_q};

endmodule
